// File: rtl/wt_wbuf_coalesce_if.sv
// Store-side and memory-side handshake bundle for the coalescing write buffer.
interface wt_wbuf_coalesce_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  st_valid_i;
  logic                  st_ready_o;
  logic [ADDR_WIDTH-1:0] st_addr_i;
  logic [DATA_WIDTH-1:0] st_data_i;
  logic [BE_WIDTH-1:0]   st_be_i;

  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [BE_WIDTH-1:0]   mem_be_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, st_be_i, mem_ready_i,
    output st_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_be_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_data_i, st_be_i, mem_ready_i,
    input  st_ready_o, mem_valid_o, mem_addr_o, mem_data_o, mem_be_o
  );
endinterface

// File: rtl/wt_wbuf_coalesce.sv
// Coalescing write buffer: FIFO of word-address entries with byte enables; a store
// to the youngest entry's word merges into it, everything else allocates at tail.
module wt_wbuf_coalesce #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MERGE_EN   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  wt_wbuf_coalesce_if.slave            bus,
  input  logic [ADDR_WIDTH-1:0]        chk_addr_i,
  output logic                         chk_hit_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [31:0]                  merge_cnt_o
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFS     = $clog2(BE_WIDTH);
  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [BE_WIDTH-1:0]   be_q   [DEPTH];
  logic [BE_WIDTH-1:0]   be_d   [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  ptr_t                  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [31:0]           merge_cnt_q, merge_cnt_d;

  logic                  st_ready, mem_valid, deq, acc;
  logic                  merge_hit, do_merge, do_alloc;
  ptr_t                  young;
  logic [ADDR_WIDTH-1:0] st_word, chk_word;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFFS) << OFFS;
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign st_ready  = (count_q < CW'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign deq       = mem_valid && bus.mem_ready_i;
  assign acc       = bus.st_valid_i && st_ready;
  assign young     = (tail_q == '0) ? ptr_t'(DEPTH - 1) : tail_q - 1'b1;
  assign st_word   = word_addr(bus.st_addr_i);
  assign chk_word  = word_addr(chk_addr_i);

  // Only the youngest entry may absorb a store, and never while it leaves as the head.
  assign merge_hit = (MERGE_EN != 0) && (count_q != '0) && (addr_q[young] == st_word) &&
                     !(deq && (young == head_q));
  assign do_merge  = acc && merge_hit;
  assign do_alloc  = acc && !merge_hit;

  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    be_d        = be_q;
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    merge_cnt_d = merge_cnt_q;

    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end

    if (do_merge) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (bus.st_be_i[b]) data_d[young][8*b +: 8] = bus.st_data_i[8*b +: 8];
      end
      be_d[young] = be_q[young] | bus.st_be_i;
      if (merge_cnt_q != '1) merge_cnt_d = merge_cnt_q + 32'd1;
    end

    if (do_alloc) begin
      addr_d[tail_q]  = st_word;
      data_d[tail_q]  = bus.st_data_i;
      be_d[tail_q]    = bus.st_be_i;
      valid_d[tail_q] = 1'b1;
      tail_d          = ptr_inc(tail_q);
    end

    case ({do_alloc, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      merge_cnt_q <= '0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      be_q        <= be_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  always_comb begin
    chk_hit_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == chk_word)) chk_hit_o = 1'b1;
    end
  end

  assign bus.st_ready_o  = st_ready;
  assign bus.mem_valid_o = mem_valid;
  assign bus.mem_addr_o  = addr_q[head_q];
  assign bus.mem_data_o  = data_q[head_q];
  assign bus.mem_be_o    = be_q[head_q];
  assign empty_o         = !mem_valid;
  assign count_o         = count_q;
  assign merge_cnt_o     = merge_cnt_q;
endmodule

// File: tb/tb_wt_wbuf_coalesce.sv
// Self-checking bench for wt_wbuf_coalesce: directed scenarios plus a randomized run
// against a queue-based reference model of the buffer.
module tb_wt_wbuf_coalesce;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] chk_addr = '0;
  logic          chk_hit;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   merge_cnt;

  int checks = 0;
  int failures = 0;

  wt_wbuf_coalesce_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wt_wbuf_coalesce #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MERGE_EN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .chk_addr_i(chk_addr),
    .chk_hit_o(chk_hit), .empty_o(empty), .count_o(count), .merge_cnt_o(merge_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mcnt = '0;
  bit          last_acc = 1'b0;
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];

  // One clock: log memory handshakes, then advance the reference model at the edge.
  task automatic cycle();
    bit m_deq, m_merge;
    ent_t e;
    logic [31:0] w;
    @(negedge clk);
    if (bus.mem_valid_o && bus.mem_ready_i) begin
      seen_addr.push_back(bus.mem_addr_o);
      seen_data.push_back(bus.mem_data_o);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mcnt = '0;
      last_acc = 1'b0;
    end else begin
      w = bus.st_addr_i & ~32'h3;
      m_deq = (mq.size() > 0) && bus.mem_ready_i;
      last_acc = bus.st_valid_i && (mq.size() < DEPTH);
      m_merge = last_acc && (mq.size() > 0) && (mq[mq.size()-1].addr == w) &&
                !(m_deq && mq.size() == 1);
      if (m_merge) begin
        e = mq[mq.size()-1];
        for (int b = 0; b < 4; b++) if (bus.st_be_i[b]) e.data[8*b +: 8] = bus.st_data_i[8*b +: 8];
        e.be = e.be | bus.st_be_i;
        mq[mq.size()-1] = e;
        if (mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
      end
      if (m_deq) void'(mq.pop_front());
      if (last_acc && !m_merge) mq.push_back('{addr: w, data: bus.st_data_i, be: bus.st_be_i});
    end
    #1;
  endtask

  task automatic set_store(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.st_valid_i = v;
    bus.st_addr_i  = a;
    bus.st_data_i  = d;
    bus.st_be_i    = be;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_store(1'b0, '0, '0, '0);
    bus.mem_ready_i = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_addr = 32'h0;
    #1;
    checks++; if (bus.st_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.st_ready_o); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (bus.mem_valid_o !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_valid_o); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (merge_cnt !== 32'd0) begin failures++; $display("FAIL reset_merge_cnt got=%0d exp=0", merge_cnt); end
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL reset_chk_hit got=%b exp=0", chk_hit); end
    checks++; if ({bus.mem_addr_o, bus.mem_data_o, bus.mem_be_o} !== '0) begin
      failures++; $display("FAIL reset_mem_regs got=%h/%h/%h exp=0", bus.mem_addr_o, bus.mem_data_o, bus.mem_be_o);
    end
  endtask

  task automatic test_merge();
    do_reset();
    set_store(1'b1, 32'h1000, 32'h0000_BBAA, 4'b0011);
    cycle();
    set_store(1'b1, 32'h1002, 32'hDDCC_0000, 4'b1100);
    cycle();
    set_store(1'b0, '0, '0, '0);
    checks++; if (count !== CW'(1)) begin failures++; $display("FAIL merge_count got=%0d exp=1", count); end
    checks++; if (bus.mem_data_o !== 32'hDDCC_BBAA) begin failures++; $display("FAIL merge_data got=%h exp=ddccbbaa", bus.mem_data_o); end
    checks++; if (bus.mem_be_o !== 4'hF) begin failures++; $display("FAIL merge_be got=%h exp=f", bus.mem_be_o); end
    checks++; if (bus.mem_addr_o !== 32'h1000) begin failures++; $display("FAIL merge_addr got=%h exp=1000", bus.mem_addr_o); end
    checks++; if (merge_cnt !== 32'd1) begin failures++; $display("FAIL merge_cnt got=%0d exp=1", merge_cnt); end
    bus.mem_ready_i = 1'b1;
    cycle();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL merge_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_ordering();
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    ea = '{32'h1000, 32'h2000, 32'h1000};
    ed = '{32'hA1, 32'hB2, 32'hA3};
    do_reset();
    seen_addr.delete(); seen_data.delete();
    set_store(1'b1, 32'h1000, 32'hA1, 4'hF); cycle();
    set_store(1'b1, 32'h2000, 32'hB2, 4'hF); cycle();
    set_store(1'b1, 32'h1000, 32'hA3, 4'hF);
    checks++; if (bus.st_ready_o !== 1'b0) begin failures++; $display("FAIL order_full_ready got=%b exp=0", bus.st_ready_o); end
    cycle();
    checks++; if (count !== CW'(2)) begin failures++; $display("FAIL order_full_count got=%0d exp=2", count); end
    bus.mem_ready_i = 1'b1;
    cycle();
    cycle();
    set_store(1'b0, '0, '0, '0);
    for (int k = 0; k < 6 && bus.mem_valid_o; k++) cycle();
    checks++; if (seen_addr.size() != 3) begin failures++; $display("FAIL order_count got=%0d exp=3", seen_addr.size()); end
    for (int i = 0; i < 3 && i < seen_addr.size(); i++) begin
      checks++;
      if (seen_addr[i] !== ea[i] || seen_data[i] !== ed[i]) begin
        failures++; $display("FAIL order_seq[%0d] got=%h/%h exp=%h/%h", i, seen_addr[i], seen_data[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_full_boundary();
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    int n;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_store(1'b1, 32'(i + 1) << 8, 32'(i), 4'hF);
      cycle();
    end
    checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", count, DEPTH); end
    set_store(1'b1, 32'h900, 32'h9, 4'hF);
    bus.mem_ready_i = 1'b1;
    checks++; if (bus.st_ready_o !== 1'b0) begin failures++; $display("FAIL full_deq_ready got=%b exp=0", bus.st_ready_o); end
    cycle();
    checks++; if (bus.st_ready_o !== 1'b1) begin failures++; $display("FAIL full_next_ready got=%b exp=1", bus.st_ready_o); end
    set_store(1'b0, '0, '0, '0);
    for (int k = 0; k < 10 && bus.mem_valid_o; k++) cycle();

    seen_addr.delete(); seen_data.delete();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      ea.push_back(32'h8000 + 32'(i) * 32'h10);
      ed.push_back($urandom);
      set_store(1'b1, ea[i], ed[i], 4'hF);
      n = 0;
      do begin
        bus.mem_ready_i = 1'($urandom_range(0, 1));
        cycle();
        n++;
      end while (!last_acc && n < 50);
      checks++; if (!last_acc) begin failures++; $display("FAIL wrap_accept[%0d] got=timeout exp=accepted", i); end
    end
    set_store(1'b0, '0, '0, '0);
    bus.mem_ready_i = 1'b1;
    for (int k = 0; k < 20 && bus.mem_valid_o; k++) cycle();
    checks++; if (seen_addr.size() != ea.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", seen_addr.size(), ea.size()); end
    for (int i = 0; i < ea.size() && i < seen_addr.size(); i++) begin
      checks++;
      if (seen_addr[i] !== ea[i] || seen_data[i] !== ed[i]) begin
        failures++; $display("FAIL wrap_seq[%0d] got=%h/%h exp=%h/%h", i, seen_addr[i], seen_data[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_head_merge_block();
    do_reset();
    set_store(1'b1, 32'h3000, 32'h11, 4'hF); cycle();
    bus.mem_ready_i = 1'b1;
    set_store(1'b1, 32'h3000, 32'h22, 4'hF); cycle();
    set_store(1'b0, '0, '0, '0);
    bus.mem_ready_i = 1'b0;
    checks++; if (count !== CW'(1)) begin failures++; $display("FAIL headblk_count got=%0d exp=1", count); end
    checks++; if (merge_cnt !== 32'd0) begin failures++; $display("FAIL headblk_merge_cnt got=%0d exp=0", merge_cnt); end
    checks++; if (bus.mem_data_o !== 32'h22 || bus.mem_addr_o !== 32'h3000) begin
      failures++; $display("FAIL headblk_entry got=%h/%h exp=3000/22", bus.mem_addr_o, bus.mem_data_o);
    end
  endtask

  task automatic test_hazard_reset();
    do_reset();
    set_store(1'b1, 32'h4000, 32'h5A, 4'hF); cycle();
    set_store(1'b0, '0, '0, '0);
    chk_addr = 32'h4003; #1;
    checks++; if (chk_hit !== 1'b1) begin failures++; $display("FAIL hazard_hit got=%b exp=1", chk_hit); end
    chk_addr = 32'h4004; #1;
    checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL hazard_miss got=%b exp=0", chk_hit); end
    set_store(1'b1, 32'h5000, 32'h6B, 4'hF); cycle();
    set_store(1'b0, '0, '0, '0);
    checks++; if (count !== CW'(2)) begin failures++; $display("FAIL hazard_count got=%0d exp=2", count); end
    bus.mem_ready_i = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.mem_ready_i = 1'b0;
    checks++; if (empty !== 1'b1 || bus.mem_valid_o !== 1'b0 || count !== '0) begin
      failures++; $display("FAIL midreset got=empty%b/valid%b/count%0d exp=1/0/0", empty, bus.mem_valid_o, count);
    end
  endtask

  task automatic test_random();
    bit exp_hit;
    logic [31:0] cw;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      set_store(1'($urandom_range(0, 1)), 32'h100 + (32'($urandom_range(0, 2)) << 2) + 32'($urandom_range(0, 3)),
                $urandom, 4'($urandom_range(0, 15)));
      bus.mem_ready_i = ($urandom_range(0, 2) == 0);
      chk_addr = 32'h100 + 32'($urandom_range(0, 15));
      #2;
      cw = chk_addr & ~32'h3;
      exp_hit = 1'b0;
      foreach (mq[i]) if (mq[i].addr == cw) exp_hit = 1'b1;
      checks++; if (bus.st_ready_o !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, bus.st_ready_o, mq.size() < DEPTH); end
      checks++; if (count !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, count, mq.size()); end
      checks++; if (empty !== (mq.size() == 0) || bus.mem_valid_o !== (mq.size() != 0)) begin
        failures++; $display("FAIL rnd_empty[%0d] got=%b/%b exp_size=%0d", n, empty, bus.mem_valid_o, mq.size());
      end
      checks++; if (merge_cnt !== mcnt) begin failures++; $display("FAIL rnd_merge_cnt[%0d] got=%0d exp=%0d", n, merge_cnt, mcnt); end
      checks++; if (chk_hit !== exp_hit) begin failures++; $display("FAIL rnd_chk_hit[%0d] got=%b exp=%b", n, chk_hit, exp_hit); end
      if (mq.size() > 0) begin
        checks++;
        if (bus.mem_addr_o !== mq[0].addr || bus.mem_data_o !== mq[0].data || bus.mem_be_o !== mq[0].be) begin
          failures++; $display("FAIL rnd_head[%0d] got=%h/%h/%h exp=%h/%h/%h", n, bus.mem_addr_o, bus.mem_data_o,
                               bus.mem_be_o, mq[0].addr, mq[0].data, mq[0].be);
        end
      end
      cycle();
    end
  endtask

  initial begin
    set_store(1'b0, '0, '0, '0);
    bus.mem_ready_i = 1'b0;
    test_reset();
    test_merge();
    test_ordering();
    test_full_boundary();
    test_head_merge_block();
    test_hazard_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/wt_wbuf_coalesce.md
# wt_wbuf_coalesce

Parametrised coalescing write buffer for the write-through data cache. It sits between the store unit and the cache memory-side request port. Each entry holds one word address with per-byte enables, and entries drain to memory in FIFO order. A store to the same word as the youngest pending entry is merged into that entry instead of allocating a new one. A combinational hazard-check port lets the load path detect pending writes, and a saturating counter reports merges to the performance counters.

## Interface

Parameters:
- DEPTH, 2: number of entries; ≥1; need not be a power of two.
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: word width; multiple of 8. BE_WIDTH = DATA_WIDTH/8, OFFS = log2(BE_WIDTH).
- MERGE_EN, 1: 0 disables coalescing, giving a plain FIFO.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset. Synchronous, active-high.
- st_valid_i, in, 1: store request valid.
- st_ready_o, out, 1: buffer can accept a store.
- st_addr_i, in, ADDR_WIDTH: store byte address. Bits [OFFS-1:0] are ignored.
- st_data_i, in, DATA_WIDTH: store data, word aligned.
- st_be_i, in, BE_WIDTH: byte enables.
- mem_valid_o, out, 1: head entry presented to memory.
- mem_ready_i, in, 1: memory accepts the head.
- mem_addr_o, out, ADDR_WIDTH: head word address, low OFFS bits zero.
- mem_data_o, out, DATA_WIDTH: head data.
- mem_be_o, out, BE_WIDTH: head byte enables.
- chk_addr_i, in, ADDR_WIDTH: load address to check.
- chk_hit_o, out, 1: some valid entry matches the word address of chk_addr_i.
- empty_o, out, 1: no valid entries.
- count_o, out, clog2(DEPTH+1): number of valid entries.
- merge_cnt_o, out, 32: saturating count of merged stores.

## Operation

- Storage is a circular buffer with head and tail pointers plus a registered count. Pointers wrap from DEPTH-1 to 0.
- **Store handshake:** a store is accepted when st_valid_i && st_ready_o. st_ready_o = (count < DEPTH). It is a registered-state function only and never depends on st_valid_i or mem_ready_i.
- **Merge condition:** all of the following must hold.
  - MERGE_EN = 1.
  - count > 0.
  - The word address of the youngest entry (tail-1) equals st_addr_i[ADDR_WIDTH-1:OFFS].
  - The youngest entry is not being dequeued this cycle, i.e. not (it is the head && mem_valid_o && mem_ready_i).
- **Merge effect:**
  - Bytes with st_be_i set overwrite data; be |= st_be_i.
  - count is unchanged and merge_cnt_o increments, saturating at 32'hFFFF_FFFF.
  - No merge is ever made into an entry older than the youngest. This preserves store ordering.
- **Allocation:** otherwise the store writes the entry at tail, sets its valid, and tail advances.
- **Drain:** mem_valid_o = !empty. mem_* outputs come directly from the head entry registers. On mem_valid_o && mem_ready_i the head entry is freed and head advances.
- **Simultaneous accept and dequeue:**
  - Count changes by +1 if allocating and -1 if dequeuing, so net 0 when both happen.
  - When full, a dequeue does not allow a same-cycle accept, because ready reflects the registered count.
- **Store with st_be_i = 0:** accepted and allocated or merged normally. Not filtered.
- **chk_hit_o:** combinational OR over valid entries of the word-address compare. Entries being dequeued or written in the current cycle are judged by their registered state.
- **Reset (rst_i high at a clock edge):**
  - head = tail = 0, count = 0, all valid bits cleared, merge_cnt_o = 0.
  - Pending entries are discarded even mid-drain. Memory-side recovery is the caller's responsibility.

## Timing

- Reset values:
  - st_ready_o = 1, mem_valid_o = 0, empty_o = 1, count_o = 0, chk_hit_o = 0, merge_cnt_o = 0.
  - mem_addr_o, mem_data_o and mem_be_o = 0, because entry registers reset to 0.
- Latency: a store accepted into an empty buffer at edge N gives mem_valid_o = 1 from cycle N+1.
- A merge at edge N is visible on mem_data_o and mem_be_o from N+1, provided the entry is still the head.
- mem_* outputs hold stable while mem_valid_o && !mem_ready_i. A merge can change data and be only when the youngest entry is not the head or no dequeue occurs that cycle. The memory side must sample only on handshake.
- Throughput: one store accepted and one entry drained per cycle.

## Test plan

- **Reset/idle:** assert rst_i for 2 cycles -> st_ready_o=1, empty_o=1, mem_valid_o=0, count_o=0, merge_cnt_o=0.
- **Merge:** DEPTH=2, mem_ready_i=0. Store 0x1000 be=4'b0011 data=0x0000_BBAA, then 0x1002 be=4'b1100 data=0xDDCC_0000 -> count_o=1, mem_data_o=0xDDCC_BBAA, mem_be_o=4'hF, merge_cnt_o=1.
- **Ordering:** store A=0x1000, B=0x2000, then A again with mem_ready_i=0 -> the third store is not accepted while full (count_o=2). After one drain it allocates a new entry, and memory sees A, B, A in order.
- **Full boundary:** fill to count_o=DEPTH, then hold st_valid_i with mem_ready_i=1 -> st_ready_o=0 in the dequeue cycle and 1 the next cycle. No entry is lost or duplicated across pointer wrap over 3·DEPTH stores.
- **Head-merge block:** single entry 0x3000 at head with mem_ready_i=1, plus a same-cycle store to 0x3000 -> it allocates a new entry (count_o stays 1) and merge_cnt_o is unchanged.
- **Hazard and reset mid-drain:** with 0x4000 pending, chk_addr_i=0x4003 -> chk_hit_o=1, and 0x4004 -> 0. Assert rst_i with 2 entries pending -> next cycle empty_o=1 and mem_valid_o=0.
